// File: rtl/key_seq_pkg.sv
// Shared types and helpers for the A/B key sequence generator.
// State encoding, key symbol encodings and counter width helpers.
package key_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP,
      DONE
   } seqState_t;

   localparam logic KEY_A = 1'b1;
   localparam logic KEY_B = 1'b0;

   // The counter must hold the larger of the two phase lengths.
   function automatic int cntWidth(input int hold, input int gap);
      int maxCycles;
      int w;
      maxCycles = (hold > gap) ? hold : gap;
      w = $clog2(maxCycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int idxWidth(input int seqLen);
      int w;
      w = $clog2(seqLen);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/key_seq_timer.sv
// Loadable down-counter with an expiry flag, shared by the PRESS and GAP phases.
// The count stops at zero rather than wrapping.
module key_seq_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadVal,
   input  logic             i_en,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_loadVal;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/key_seq_gen.sv
// Plays a latched A/B symbol pattern onto the A and B key lines with hold and gap timing.
// Define KEY_SEQ_GEN_LOOP_EN to repeat the pattern until a stop request is seen.
module key_seq_gen
   import key_seq_pkg::*;
#(
   parameter int SEQ_LEN     = 8,
   parameter int HOLD_CYCLES = 20,
   parameter int GAP_CYCLES  = 20,
   parameter int LEN_W       = $clog2(SEQ_LEN + 1)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [SEQ_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
`ifdef KEY_SEQ_GEN_LOOP_EN
   input  logic               stop,
`endif
   output logic               A,
   output logic               B,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = cntWidth(HOLD_CYCLES, GAP_CYCLES);
   localparam int IDX_W = idxWidth(SEQ_LEN);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seqState_t          r_state, w_stateNext;
   logic [SEQ_LEN-1:0] r_pat, w_patNext;
   logic [LEN_W-1:0]   r_len, w_lenNext, w_lenClamped;
   logic [IDX_W-1:0]   r_idx, w_idxNext;
   logic [CNT_W-1:0]   w_loadVal;
   logic               w_load, w_expired, w_last, w_repeat, w_symNext;
   logic               w_aNext, w_bNext, w_busyNext, w_doneNext;
   logic               r_A, r_B, r_busy, r_done;

   assign w_lenClamped = (32'(len) > SEQ_LEN) ? LEN_W'(SEQ_LEN) : len;
   assign w_last       = ((LEN_W'(r_idx) + LEN_W'(1)) == r_len);

`ifdef KEY_SEQ_GEN_LOOP_EN
   logic w_accept;
   logic r_stopFlag;

   assign w_accept = (r_state == IDLE) && start;

   // A stop request arms a sticky flag; the pass in progress still completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stopFlag <= 1'b0;
      end else if (w_accept) begin
         r_stopFlag <= stop;
      end else if (stop) begin
         r_stopFlag <= 1'b1;
      end
   end

   assign w_repeat = ~(r_stopFlag | stop);
`else
   assign w_repeat = 1'b0;
`endif

   key_seq_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rstn      (rstn),
      .i_load    (w_load),
      .i_loadVal (w_loadVal),
      .i_en      ((r_state == PRESS) || (r_state == GAP)),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_pat   <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_A     <= 1'b0;
         r_B     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_pat   <= w_patNext;
         r_len   <= w_lenNext;
         r_idx   <= w_idxNext;
         r_A     <= w_aNext;
         r_B     <= w_bNext;
         r_busy  <= w_busyNext;
         r_done  <= w_doneNext;
      end
   end

   // Outputs are computed from the next state so the first key rises right after acceptance.
   always_comb begin
      w_stateNext = r_state;
      w_patNext   = r_pat;
      w_lenNext   = r_len;
      w_idxNext   = r_idx;
      w_load      = 1'b0;
      w_loadVal   = HOLD_LOAD;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_patNext = pattern;
               w_lenNext = w_lenClamped;
               w_idxNext = '0;
               if (w_lenClamped == '0) begin
                  w_stateNext = DONE;
               end else begin
                  w_stateNext = PRESS;
                  w_load      = 1'b1;
               end
            end
         end
         PRESS, GAP: begin
            if (w_expired) begin
               if ((r_state == PRESS) && (GAP_CYCLES > 0)) begin
                  w_stateNext = GAP;
                  w_load      = 1'b1;
                  w_loadVal   = GAP_LOAD;
               end else if (!w_last) begin
                  w_stateNext = PRESS;
                  w_idxNext   = r_idx + 1'b1;
                  w_load      = 1'b1;
               end else if (w_repeat) begin
                  w_stateNext = PRESS;
                  w_idxNext   = '0;
                  w_load      = 1'b1;
               end else begin
                  w_stateNext = DONE;
               end
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      w_symNext  = w_patNext[w_idxNext];
      w_aNext    = (w_stateNext == PRESS) && (w_symNext == KEY_A);
      w_bNext    = (w_stateNext == PRESS) && (w_symNext == KEY_B);
      w_busyNext = (w_stateNext == PRESS) || (w_stateNext == GAP);
      w_doneNext = (w_stateNext == DONE);
   end

   assign A    = r_A;
   assign B    = r_B;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_key_seq_gen.sv
// Directed scoreboard bench for key_seq_gen: one gapped instance and one gapless instance.
// Per-cycle expected {A,B,busy,done} values are queued when a start is driven.
module tb_key_seq_gen;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start0, start1;
   logic [7:0] pat0, pat1;
   logic [3:0] len0, len1;
   logic       stop0, stop1;
   logic       a0, b0, busy0, done0;
   logic       a1, b1, busy1, done1;

   logic [3:0] q0[$];
   logic [3:0] q1[$];
   int         nCmp = 0;
   int         nFail = 0;

   always #5 clk = ~clk;

   key_seq_gen #(
      .SEQ_LEN(8), .HOLD_CYCLES(4), .GAP_CYCLES(2)
   ) dut0 (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start0),
      .pattern (pat0),
      .len     (len0),
`ifdef KEY_SEQ_GEN_LOOP_EN
      .stop    (stop0),
`endif
      .A       (a0),
      .B       (b0),
      .busy    (busy0),
      .done    (done0)
   );

   key_seq_gen #(
      .SEQ_LEN(8), .HOLD_CYCLES(4), .GAP_CYCLES(0)
   ) dut1 (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start1),
      .pattern (pat1),
      .len     (len1),
`ifdef KEY_SEQ_GEN_LOOP_EN
      .stop    (stop1),
`endif
      .A       (a1),
      .B       (b1),
      .busy    (busy1),
      .done    (done1)
   );

   task automatic push(input int which, input logic [3:0] val);
      if (which == 0) q0.push_back(val);
      else q1.push_back(val);
   endtask

   // Expected trace of one pass: each symbol held, then the idle gap, busy throughout.
   task automatic pushSymbols(input int which, input logic [7:0] pat, input int len,
                              input int hold, input int gap);
      int n;
      n = (len > 8) ? 8 : len;
      for (int s = 0; s < n; s++) begin
         for (int c = 0; c < hold; c++) push(which, {pat[s], ~pat[s], 1'b1, 1'b0});
         for (int c = 0; c < gap; c++) push(which, 4'b0010);
      end
   endtask

   task automatic pushDone(input int which);
      push(which, 4'b0001);
   endtask

   task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      nCmp++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [7:0] pat, input logic [3:0] len);
      if (which == 0) begin
         pat0 = pat; len0 = len; start0 = 1'b1;
      end else begin
         pat1 = pat; len1 = len; start1 = 1'b1;
      end
   endtask

   task automatic checkOutput();
      logic [3:0] exp0, exp1;
      exp0 = (q0.size() > 0) ? q0.pop_front() : 4'b0000;
      exp1 = (q1.size() > 0) ? q1.pop_front() : 4'b0000;
      compare("dut0_trace", {a0, b0, busy0, done0}, exp0);
      compare("dut1_trace", {a1, b1, busy1, done1}, exp1);
      compare("dut0_overlap", {3'b000, a0 & b0}, 4'b0000);
      compare("dut1_overlap", {3'b000, a1 & b1}, 4'b0000);
   endtask

   task automatic runCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         checkOutput();
      end
   endtask

   initial begin
      rstn = 1'b0;
      start0 = 1'b0; start1 = 1'b0;
      pat0 = '0; pat1 = '0; len0 = '0; len1 = '0;
      stop0 = 1'b0; stop1 = 1'b0;

      #12;
      compare("reset_dut0", {a0, b0, busy0, done0}, 4'b0000);
      compare("reset_dut1", {a1, b1, busy1, done1}, 4'b0000);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      runCycles(2);

      $display("[TB] ABBAA sequence");
      applyStimulus(0, 8'h19, 4'd5);
      pushSymbols(0, 8'h19, 5, 4, 2);
      pushDone(0);
      runCycles(1);
      start0 = 1'b0;
      runCycles(33);

      $display("[TB] len=0");
      applyStimulus(0, 8'hFF, 4'd0);
      pushDone(0);
      runCycles(1);
      start0 = 1'b0;
      runCycles(3);

      $display("[TB] len=12 clamps to 8");
      applyStimulus(0, 8'hA5, 4'd12);
      pushSymbols(0, 8'hA5, 12, 4, 2);
      pushDone(0);
      runCycles(1);
      start0 = 1'b0;
      runCycles(51);

      $display("[TB] start held high");
      applyStimulus(0, 8'h02, 4'd2);
      pushSymbols(0, 8'h02, 2, 4, 2);
      pushDone(0);
      push(0, 4'b0000);
      pushSymbols(0, 8'h02, 2, 4, 2);
      pushDone(0);
      runCycles(16);
      start0 = 1'b0;
      runCycles(14);

      $display("[TB] gapless AB");
      applyStimulus(1, 8'h01, 4'd2);
      pushSymbols(1, 8'h01, 2, 4, 0);
      pushDone(1);
      runCycles(1);
      start1 = 1'b0;
      runCycles(11);

`ifdef KEY_SEQ_GEN_LOOP_EN
      $display("[TB] loop with stop in second pass");
      applyStimulus(0, 8'h05, 4'd3);
      pushSymbols(0, 8'h05, 3, 4, 2);
      pushSymbols(0, 8'h05, 3, 4, 2);
      pushDone(0);
      runCycles(1);
      start0 = 1'b0;
      runCycles(24);
      stop0 = 1'b1;
      runCycles(1);
      stop0 = 1'b0;
      runCycles(14);
`endif

      $display("[TB] reset mid-PRESS");
      applyStimulus(0, 8'h19, 4'd5);
      pushSymbols(0, 8'h19, 5, 4, 2);
      pushDone(0);
      runCycles(1);
      start0 = 1'b0;
      runCycles(1);
      rstn = 1'b0;
      #2;
      compare("async_reset_dut0", {a0, b0, busy0, done0}, 4'b0000);
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      runCycles(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
